// File: rtl/dcache_mshr.sv
// Miss-status holding buffer: tracks accepted memory requests by bus tag, registers fills and answers line-pending lookups.
// Optional per-entry age watchdog (err_timeout, timeout_lsq_idx) is built when MSHR_WATCHDOG_EN is defined.
`ifndef DCACHE_BLOCK_OFFSET
`define DCACHE_BLOCK_OFFSET 6
`endif
`ifndef DCACHE_INDEX_SIZE
`define DCACHE_INDEX_SIZE 4
`endif
`ifndef DCACHE_TAG_SIZE
`define DCACHE_TAG_SIZE 54
`endif
`ifndef DCACHE_BLOCK_SIZE
`define DCACHE_BLOCK_SIZE 512
`endif

module dcache_mshr #(
  parameter int N_ENTRIES = 4,
  parameter int LSQ_IDX_W = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alloc_valid,
  input  logic [63:0]                   alloc_addr,
  input  logic                          alloc_is_store,
  input  logic [LSQ_IDX_W-1:0]          alloc_lsq_idx,
  input  logic [3:0]                    mem_response,
  input  logic [3:0]                    mem_tag,
  input  logic [`DCACHE_BLOCK_SIZE-1:0] mem_data,
  input  logic [63:0]                   lookup_addr,
  output logic                          lookup_pending,
  output logic                          fill_valid,
  output logic [`DCACHE_INDEX_SIZE-1:0] fill_index,
  output logic [`DCACHE_TAG_SIZE-1:0]   fill_tag,
  output logic [`DCACHE_BLOCK_SIZE-1:0] fill_data,
  output logic [LSQ_IDX_W-1:0]          fill_lsq_idx,
  output logic                          fill_is_store,
  output logic                          mshr_full,
  output logic                          mshr_empty,
  output logic                          err_overflow,
`ifdef MSHR_WATCHDOG_EN
  output logic                          err_timeout,
  output logic [LSQ_IDX_W-1:0]          timeout_lsq_idx,
`endif
  output logic                          err_spurious
);

  localparam int OFF    = `DCACHE_BLOCK_OFFSET;
  localparam int IDX_W  = `DCACHE_INDEX_SIZE;
  localparam int TAG_W  = `DCACHE_TAG_SIZE;
  localparam int DATA_W = `DCACHE_BLOCK_SIZE;
  localparam int SEL_W  = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           mem_tag;
    logic [TAG_W-1:0]     ltag;
    logic [IDX_W-1:0]     lidx;
    logic                 is_store;
    logic [LSQ_IDX_W-1:0] lsq_idx;
  } entry_t;

  typedef struct packed {
    logic                 valid;
    logic [IDX_W-1:0]     index;
    logic [TAG_W-1:0]     tag;
    logic [DATA_W-1:0]    data;
    logic [LSQ_IDX_W-1:0] lsq_idx;
    logic                 is_store;
  } fill_t;

  entry_t ent_q [N_ENTRIES];
  entry_t ent_d [N_ENTRIES];
  fill_t  fill_q, fill_d;
  logic   full_q, full_d, empty_q, empty_d;
  logic   overflow_q, overflow_d, spurious_q, spurious_d;

  logic             hit_found, free_found, tag_clash, alloc_ok;
  logic [SEL_W-1:0] hit_sel, free_sel;

  // Line-offset bits never take part in matching.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{alloc_addr[OFF-1:0], lookup_addr[OFF-1:0]};

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
    ent_d      = ent_q;
    fill_d     = '0;
    overflow_d = overflow_q;
    hit_found  = 1'b0;
    hit_sel    = '0;
    free_found = 1'b0;
    free_sel   = '0;
    tag_clash  = 1'b0;
    alloc_ok   = 1'b0;

    for (int i = 0; i < N_ENTRIES; i++) begin
      if (ent_q[i].valid && mem_tag != 4'd0 && ent_q[i].mem_tag == mem_tag) begin
        if (!hit_found) begin
          hit_found = 1'b1;
          hit_sel   = SEL_W'(i);
        end
      end else if (ent_q[i].valid && ent_q[i].mem_tag == mem_response) begin
        tag_clash = 1'b1;
      end
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_sel   = SEL_W'(i);
      end
    end

    if (hit_found) begin
      ent_d[hit_sel].valid = 1'b0;
      fill_d.valid         = 1'b1;
      fill_d.index         = ent_q[hit_sel].lidx;
      fill_d.tag           = ent_q[hit_sel].ltag;
      fill_d.data          = mem_data;
      fill_d.lsq_idx       = ent_q[hit_sel].lsq_idx;
      fill_d.is_store      = ent_q[hit_sel].is_store;
    end
    spurious_d = (mem_tag != 4'd0) && !hit_found;

    // The slot freed by a same-cycle completion is not a candidate: free_sel uses start-of-cycle state.
    if (alloc_valid && mem_response != 4'd0) begin
      if (!free_found || tag_clash) begin
        overflow_d = 1'b1;
      end else begin
        alloc_ok                  = 1'b1;
        ent_d[free_sel].valid     = 1'b1;
        ent_d[free_sel].mem_tag   = mem_response;
        ent_d[free_sel].ltag      = alloc_addr[63 -: TAG_W];
        ent_d[free_sel].lidx      = alloc_addr[OFF +: IDX_W];
        ent_d[free_sel].is_store  = alloc_is_store;
        ent_d[free_sel].lsq_idx   = alloc_lsq_idx;
      end
    end

    full_d  = 1'b1;
    empty_d = 1'b1;
    for (int i = 0; i < N_ENTRIES; i++) begin
      full_d  = full_d & ent_d[i].valid;
      empty_d = empty_d & ~ent_d[i].valid;
    end
  end

  // Completing entries still count as pending so a racing miss is not re-issued.
  always_comb begin
    lookup_pending = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (ent_q[i].valid && !ent_q[i].is_store &&
          {ent_q[i].ltag, ent_q[i].lidx} == lookup_addr[63:OFF])
        lookup_pending = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the entry table is reset because valid bits must be known; payload fields could be left alone.
      for (int i = 0; i < N_ENTRIES; i++) ent_q[i] <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) ent_q[i] <= ent_d[i];
      fill_q     <= fill_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      spurious_q <= spurious_d;
    end
  end

`ifdef MSHR_WATCHDOG_EN
  logic [7:0]           age_q [N_ENTRIES];
  logic [7:0]           age_d [N_ENTRIES];
  logic                 timeout_q, timeout_d, to_found;
  logic [LSQ_IDX_W-1:0] tlsq_q, tlsq_d;

  always_comb begin
    age_d     = age_q;
    timeout_d = timeout_q;
    tlsq_d    = tlsq_q;
    to_found  = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (ent_q[i].valid && age_q[i] != 8'hFF) age_d[i] = age_q[i] + 8'd1;
      if (ent_q[i].valid && age_q[i] == 8'hFF && !timeout_q && !to_found) begin
        to_found  = 1'b1;
        timeout_d = 1'b1;
        tlsq_d    = ent_q[i].lsq_idx;
      end
    end
    if (alloc_ok) age_d[free_sel] = 8'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) age_q[i] <= 8'd0;
      timeout_q <= 1'b0;
      tlsq_q    <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) age_q[i] <= age_d[i];
      timeout_q <= timeout_d;
      tlsq_q    <= tlsq_d;
    end
  end

  assign err_timeout     = timeout_q;
  assign timeout_lsq_idx = tlsq_q;
`endif

  assign fill_valid    = fill_q.valid;
  assign fill_index    = fill_q.index;
  assign fill_tag      = fill_q.tag;
  assign fill_data     = fill_q.data;
  assign fill_lsq_idx  = fill_q.lsq_idx;
  assign fill_is_store = fill_q.is_store;
  assign mshr_full     = full_q;
  assign mshr_empty    = empty_q;
  assign err_overflow  = overflow_q;
  assign err_spurious  = spurious_q;

endmodule
